cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Sits downstream of the pipeline's I-cache and D-cache and upstream of the cacheline adaptor / physical memory.
- Serialises line-fill and write-back requests from both caches onto a single physical memory port.
- Latches each granted request and returns the line data with a one-cycle response pulse to the requester.
- Data-side priority by default, because the data access belongs to an older instruction; prevents I-fetch starvation of loads and stores.

Parameters:
ADDR_WIDTH, 32, width of all line addresses
LINE_WIDTH, 256, cacheline width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
i_read  input  1  I-cache line read request; held until i_resp
i_addr  input  ADDR_WIDTH  I-cache line address
i_rdata  output  LINE_WIDTH  line returned to I-cache; valid only with i_resp
i_resp  output  1  one-cycle completion pulse to I-cache
d_read  input  1  D-cache line read request; held until d_resp
d_write  input  1  D-cache line write-back request; held until d_resp
d_addr  input  ADDR_WIDTH  D-cache line address
d_wdata  input  LINE_WIDTH  write-back line
d_rdata  output  LINE_WIDTH  line returned to D-cache; valid only with d_resp
d_resp  output  1  one-cycle completion pulse to D-cache
pmem_read  output  1  memory read request, registered
pmem_write  output  1  memory write request, registered
pmem_addr  output  ADDR_WIDTH  memory address, registered
pmem_wdata  output  LINE_WIDTH  memory write line, registered
pmem_rdata  input  LINE_WIDTH  memory read line; valid with pmem_resp
pmem_resp  input  1  memory completion, one cycle

Behaviour:
- Reset:
  - State goes to IDLE.
  - pmem_read, pmem_write, i_resp, d_resp all go to 0.
  - pmem_addr, pmem_wdata and the line buffer go to 0.
  - All of the above take effect immediately (async), including in the middle of a transfer; any in-flight transfer is abandoned.
- State IDLE:
  - Samples requests each cycle.
  - Grant order: d_read|d_write first, then i_read.
  - On grant, latches addr, op and wdata into pmem_* registers and moves to BUSY_D or BUSY_I.
  - pmem_read/pmem_write are asserted from the cycle after the grant cycle.
  - No request: stays in IDLE with all outputs 0.
- State BUSY_D / BUSY_I:
  - pmem_* are held constant, independent of the client inputs; client changes mid-transfer are ignored.
  - On pmem_resp=1: capture pmem_rdata into the line buffer (writes capture too, ignored by the client), clear pmem_read/pmem_write at the next edge, move to RESP_D / RESP_I.
- State RESP_D / RESP_I:
  - Asserts d_resp or i_resp for exactly one cycle.
  - i_rdata and d_rdata both drive the line buffer.
  - No arbitration occurs in this cycle; next state is IDLE.
- Timing:
  - Minimum latency from request seen in IDLE to resp = memory latency + 2 cycles (grant edge, pmem edge ... pmem_resp edge, resp cycle).
  - Back-to-back grants are separated by at least one IDLE cycle.
- pmem_resp while in IDLE or RESP_*: ignored, no state change.
- d_read and d_write both high: illegal. Treated as a write. A simulation-only assertion fires.
- pmem_read and pmem_write are never both 1. Never more than one resp high.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Adds a 1-bit last_grant register, reset to I-side.
  - When both caches request in the same IDLE cycle, the side not granted last wins.
  - last_grant updates on every grant.
  - Single requests are granted as normal.
- Undefined: fixed D-over-I priority; no last_grant register.

Test Plan:
- Single I read: i_read=1, i_addr=0x0000_0060, memory responds 3 cycles after pmem_read rises with line 0xA5..A5 -> pmem_read high with pmem_addr=0x60 from cycle 1; i_resp pulses once with i_rdata=0xA5..A5; d_resp stays 0.
- D write-back: d_write=1, d_addr=0x8000_0020, d_wdata=0x1234..; pmem_resp after 2 cycles -> pmem_write=1, pmem_wdata matches; pmem_read stays 0; d_resp pulses once; state returns to IDLE.
- Simultaneous requests (i_read=1, d_read=1 at the same edge), macro undefined -> D serviced first, then I; two resps in order d then i, separated by at least 1 IDLE cycle. Macro defined -> first tie goes to D, a second tie immediately after goes to I.
- Mid-transfer input change: during BUSY_I, change i_addr from 0x40 to 0x80 -> pmem_addr stays 0x40 until pmem_resp.
- Reset mid-operation: assert rst in BUSY_D while pmem_read=1 -> pmem_read drops in the same cycle without waiting for a clock edge; after release, state is IDLE; a stale pmem_resp is ignored, with no resp pulse.
- Spurious pmem_resp in IDLE -> no i_resp/d_resp, state stays IDLE.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory signals around cache_arbiter.
// slave  : the arbiter's view (consumes cache requests, drives pmem and responses).
// master : the surrounding environment (caches plus memory).
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  // I-cache side
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  // D-cache side
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  // physical memory side
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: serialises I-cache and D-cache line fills / write-backs onto one
// physical memory port. One transfer at a time: IDLE -> BUSY_x -> RESP_x -> IDLE.
// D-side wins ties by default (older instruction). Defining ARB_ROUND_ROBIN_EN
// adds a last_grant register so that ties alternate between the two caches.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_D = 3'd1,
    BUSY_I = 3'd2,
    RESP_D = 3'd3,
    RESP_I = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  dcache_req, icache_req;
  logic                  gnt_dcache, gnt_icache;
  logic                  busy;
  logic                  pmem_read_q, pmem_write_q;
  logic [ADDR_WIDTH-1:0] pmem_addr_q;
  logic [LINE_WIDTH-1:0] pmem_wdata_q;
  logic [LINE_WIDTH-1:0] line_q;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic LAST_D = 1'b0;
  localparam logic LAST_I = 1'b1;
  logic last_grant_q;
`endif

  // a simultaneous read+write from the D-cache is handled as a write-back
  assign dcache_req = bus.d_read | bus.d_write;
  assign icache_req = bus.i_read;
  assign busy       = (state_q == BUSY_D) || (state_q == BUSY_I);

  // state register; async reset abandons any in-flight transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // arbitration and next-state decode; grants only happen in IDLE
  always_comb begin
    state_d    = state_q;
    gnt_dcache = 1'b0;
    gnt_icache = 1'b0;
    unique case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (dcache_req && icache_req) begin
          if (last_grant_q == LAST_I) gnt_dcache = 1'b1;
          else                        gnt_icache = 1'b1;
        end else if (dcache_req) begin
          gnt_dcache = 1'b1;
        end else if (icache_req) begin
          gnt_icache = 1'b1;
        end
`else
        if (dcache_req)      gnt_dcache = 1'b1;
        else if (icache_req) gnt_icache = 1'b1;
`endif
        if (gnt_dcache)      state_d = BUSY_D;
        else if (gnt_icache) state_d = BUSY_I;
      end
      BUSY_D:  if (bus.pmem_resp) state_d = RESP_D;
      BUSY_I:  if (bus.pmem_resp) state_d = RESP_I;
      RESP_D:  state_d = IDLE;
      RESP_I:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // memory-side registers: load on grant, hold while busy, drop on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
      line_q       <= '0;
    end else if (gnt_dcache) begin
      pmem_addr_q  <= bus.d_addr;
      pmem_wdata_q <= bus.d_wdata;
      pmem_write_q <= bus.d_write;
      pmem_read_q  <= ~bus.d_write;
    end else if (gnt_icache) begin
      pmem_addr_q  <= bus.i_addr;
      pmem_write_q <= 1'b0;
      pmem_read_q  <= 1'b1;
    end else if (busy && bus.pmem_resp) begin
      // write completions capture too; the D-cache ignores the data then
      line_q       <= bus.pmem_rdata;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // remember which cache was served last so ties alternate
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             last_grant_q <= LAST_I;
    else if (gnt_dcache) last_grant_q <= LAST_D;
    else if (gnt_icache) last_grant_q <= LAST_I;
  end
`endif

  // responses decode straight from state so reset clears them immediately
  assign bus.i_resp     = (state_q == RESP_I);
  assign bus.d_resp     = (state_q == RESP_D);
  assign bus.i_rdata    = line_q;
  assign bus.d_rdata    = line_q;
  assign bus.pmem_read  = pmem_read_q;
  assign bus.pmem_write = pmem_write_q;
  assign bus.pmem_addr  = pmem_addr_q;
  assign bus.pmem_wdata = pmem_wdata_q;

`ifndef SYNTHESIS
  a_no_rd_and_wr: assert property (@(posedge clk) disable iff (rst)
    !(bus.d_read && bus.d_write));
  a_pmem_one_op: assert property (@(posedge clk) disable iff (rst)
    !(pmem_read_q && pmem_write_q));
  a_one_resp: assert property (@(posedge clk) disable iff (rst)
    $onehot0({bus.i_resp, bus.d_resp}));
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: plays both caches and the physical memory.
// The reference model works at transaction level: who wins each arbitration,
// which address/op reaches memory, and what line comes back.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int SIDE_D = 0;
  localparam int SIDE_I = 1;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int            last_side;
  logic [LW-1:0] mem_model [logic [AW-1:0]];

  function automatic int model_pick(input bit d_pend, input bit i_pend);
    if (d_pend && i_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last_side == SIDE_I) ? SIDE_D : SIDE_I;
`else
      return SIDE_D;
`endif
    end
    return d_pend ? SIDE_D : SIDE_I;
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {8{a ^ 32'h5A5A_0F0F}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 7)) << 5;
    if ($urandom_range(0, 1) == 1) a = a | 32'h8000_0000;
    return a;
  endfunction

  // Serve one granted transfer as the memory and check every step of it.
  // Called at a negedge with the arbiter idle (or about to be) and the request up.
  task automatic do_grant(input int side, input logic [AW-1:0] exp_addr, input bit exp_write,
                          input logic [LW-1:0] exp_wdata, input int lat, input bit perturb,
                          input logic [LW-1:0] rline);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.pmem_read || bus.pmem_write) && n < 20) begin
      n++;
      @(negedge clk);
    end
    tests_run++;
    if (n !== 0) begin
      tests_failed++;
      $display("FAIL grant_delay: got %0d idle cycles, expected 0", n);
    end
    tests_run++;
    if ({bus.pmem_read, bus.pmem_write, bus.pmem_addr} !== {!exp_write, exp_write, exp_addr}) begin
      tests_failed++;
      $display("FAIL pmem_req: got rd=%b wr=%b addr=%h, expected rd=%b wr=%b addr=%h",
               bus.pmem_read, bus.pmem_write, bus.pmem_addr, !exp_write, exp_write, exp_addr);
    end
    if (exp_write) begin
      tests_run++;
      if (bus.pmem_wdata !== exp_wdata) begin
        tests_failed++;
        $display("FAIL pmem_wdata: got %h expected %h", bus.pmem_wdata, exp_wdata);
      end
    end
    for (int k = 0; k < lat; k++) begin
      if (perturb) begin
        if (side == SIDE_D) begin
          bus.d_addr  = exp_addr ^ 32'h0000_00C0;
          bus.d_wdata = ~exp_wdata;
        end else begin
          bus.i_addr = exp_addr ^ 32'h0000_00C0;
        end
      end
      @(negedge clk);
      tests_run++;
      if ({bus.pmem_read, bus.pmem_write, bus.pmem_addr, bus.i_resp, bus.d_resp} !==
          {!exp_write, exp_write, exp_addr, 2'b00}) begin
        tests_failed++;
        $display("FAIL hold: got rd=%b wr=%b addr=%h iresp=%b dresp=%b, expected rd=%b wr=%b addr=%h no resp",
                 bus.pmem_read, bus.pmem_write, bus.pmem_addr, bus.i_resp, bus.d_resp,
                 !exp_write, exp_write, exp_addr);
      end
      if (exp_write) begin
        tests_run++;
        if (bus.pmem_wdata !== exp_wdata) begin
          tests_failed++;
          $display("FAIL hold_wdata: got %h expected %h", bus.pmem_wdata, exp_wdata);
        end
      end
    end
    bus.pmem_rdata = rline;
    bus.pmem_resp  = 1'b1;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = rand_line();
    tests_run++;
    if ({bus.d_resp, bus.i_resp, bus.pmem_read, bus.pmem_write} !==
        {side == SIDE_D, side == SIDE_I, 2'b00}) begin
      tests_failed++;
      $display("FAIL resp: got dresp=%b iresp=%b rd=%b wr=%b, expected dresp=%b iresp=%b rd=0 wr=0",
               bus.d_resp, bus.i_resp, bus.pmem_read, bus.pmem_write, side == SIDE_D, side == SIDE_I);
    end
    tests_run++;
    if ({bus.i_rdata, bus.d_rdata} !== {rline, rline}) begin
      tests_failed++;
      $display("FAIL rdata: got i=%h d=%h expected %h", bus.i_rdata, bus.d_rdata, rline);
    end
    if (side == SIDE_D) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end else begin
      bus.i_read = 1'b0;
    end
    @(negedge clk);
    tests_run++;
    if ({bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL idle_gap: got iresp=%b dresp=%b rd=%b wr=%b, expected all 0",
               bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write);
    end
    last_side = side;
    if (exp_write) mem_model[exp_addr] = exp_wdata;
    $display("[TB] txn side=%s op=%s addr=%h lat=%0d perturb=%0d",
             (side == SIDE_D) ? "D" : "I", exp_write ? "WR" : "RD", exp_addr, lat, perturb);
  endtask

  task automatic clear_inputs();
    bus.i_read     = 1'b0;
    bus.i_addr     = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    tests_run++;
    if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
    end
    @(negedge clk);
    rst = 1'b0;
    last_side = SIDE_I;
    @(negedge clk);
    tests_run++;
    if ({bus.pmem_addr, bus.pmem_wdata, bus.i_rdata, bus.d_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h wdata=%h line=%h expected all 0",
               bus.pmem_addr, bus.pmem_wdata, bus.i_rdata);
    end
    tests_run++;
    if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL idle_no_req: got %b expected 0000",
               {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
    end
  endtask

  task automatic test_single_i_read();
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_0060;
    do_grant(SIDE_I, 32'h0000_0060, 1'b0, '0, 3, 1'b0, {32{8'hA5}});
  endtask

  task automatic test_d_writeback();
    logic [LW-1:0] wd;
    wd = {16{16'h1234}};
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h8000_0020;
    bus.d_wdata = wd;
    do_grant(SIDE_D, 32'h8000_0020, 1'b1, wd, 2, 1'b0, rand_line());
  endtask

  // tie at the first arbitration, and a second tie right after by re-raising D
  task automatic test_back_to_back();
    bit d_pend, i_pend, reraise;
    logic [AW-1:0] da, ia;
    int side;
    da = 32'h0000_0200;
    ia = 32'h0000_0100;
    bus.d_read = 1'b1; bus.d_addr = da;
    bus.i_read = 1'b1; bus.i_addr = ia;
    d_pend = 1'b1; i_pend = 1'b1; reraise = 1'b1;
    while (d_pend || i_pend) begin
      side = model_pick(d_pend, i_pend);
      if (side == SIDE_D) begin
        do_grant(SIDE_D, da, 1'b0, '0, 1, 1'b0, mem_line(da));
        d_pend = 1'b0;
      end else begin
        do_grant(SIDE_I, ia, 1'b0, '0, 1, 1'b0, mem_line(ia));
        i_pend = 1'b0;
      end
      if (reraise && i_pend) begin
        reraise = 1'b0;
        d_pend = 1'b1;
        da = 32'h0000_0300;
        bus.d_read = 1'b1;
        bus.d_addr = da;
      end
    end
  endtask

  task automatic test_mid_change();
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_0040;
    do_grant(SIDE_I, 32'h0000_0040, 1'b0, '0, 3, 1'b1, mem_line(32'h0000_0040));
  endtask

  task automatic test_reset_mid();
    bus.d_read = 1'b1;
    bus.d_addr = 32'h0000_0500;
    @(negedge clk);
    tests_run++;
    if (bus.pmem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pre: got pmem_read=%b expected 1", bus.pmem_read);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.pmem_read, bus.pmem_write, bus.d_resp, bus.pmem_addr} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got rd=%b wr=%b dresp=%b addr=%h expected all 0",
               bus.pmem_read, bus.pmem_write, bus.d_resp, bus.pmem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.d_read = 1'b0;
    last_side = SIDE_I;
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = rand_line();
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write, bus.d_rdata} !== '0) begin
        tests_failed++;
        $display("FAIL rstmid_stale: got iresp=%b dresp=%b rd=%b wr=%b line=%h expected all 0",
                 bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write, bus.d_rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_spurious_resp();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rand_line();
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL spurious: got iresp=%b dresp=%b rd=%b wr=%b expected all 0",
                 bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write);
      end
      @(negedge clk);
    end
    // a normal request must still be granted immediately afterwards
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_0080;
    do_grant(SIDE_I, 32'h0000_0080, 1'b0, '0, 0, 1'b0, mem_line(32'h0000_0080));
  endtask

  task automatic test_random();
    bit d_pend, i_pend, d_wr, reraise;
    logic [AW-1:0] da, ia;
    logic [LW-1:0] dwd;
    int pick, side;
    for (int r = 0; r < 30; r++) begin
      pick   = $urandom_range(0, 2);
      d_pend = (pick != 1);
      i_pend = (pick != 0);
      if (d_pend) begin
        d_wr = 1'($urandom_range(0, 1));
        da = rand_addr(); dwd = rand_line();
        bus.d_read = !d_wr; bus.d_write = d_wr; bus.d_addr = da; bus.d_wdata = dwd;
      end
      if (i_pend) begin
        ia = rand_addr();
        bus.i_read = 1'b1; bus.i_addr = ia;
      end
      reraise = 1'($urandom_range(0, 1));
      while (d_pend || i_pend) begin
        side = model_pick(d_pend, i_pend);
        if (side == SIDE_D) begin
          do_grant(SIDE_D, da, d_wr, dwd, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                   d_wr ? rand_line() : mem_line(da));
          d_pend = 1'b0;
        end else begin
          do_grant(SIDE_I, ia, 1'b0, '0, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                   mem_line(ia));
          i_pend = 1'b0;
        end
        if (reraise && i_pend) begin
          reraise = 1'b0;
          d_pend = 1'b1;
          d_wr = 1'($urandom_range(0, 1));
          da = rand_addr(); dwd = rand_line();
          bus.d_read = !d_wr; bus.d_write = d_wr; bus.d_addr = da; bus.d_wdata = dwd;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_side    = SIDE_I;
    test_reset();
    test_single_i_read();
    test_d_writeback();
    test_back_to_back();
    test_mid_change();
    test_reset_mid();
    test_spurious_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
